// File: rtl/mips_mem_pkg.sv
// Shared types for the MIPS two-port memory arbiter: FSM states, grant encoding, reset grant.
package mips_mem_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } arb_state_t;

    typedef enum logic {
        INSTR = 1'b0,
        DATA  = 1'b1
    } grant_t;

    // INSTR as the reset value makes data win the first tie
    localparam grant_t LAST_GRANT_RST = INSTR;
    localparam int     CNT_W          = 4;

endpackage

// File: rtl/mips_mem_arbiter.sv
// Purpose: serialises fetch and load/store requests onto one fixed-latency single-port memory.
// Latency: request-to-ready MEM_LAT+2 cycles; one access per MEM_LAT+3 cycles under load.
// Backpressure: requests are levels held until ready; ties alternate, nothing queued beyond the level.
module mips_mem_arbiter
    import mips_mem_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int MEM_LAT = 2
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_ready,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_ready,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    localparam logic [CNT_W-1:0] LAT_LOAD = CNT_W'(MEM_LAT - 1);

    arb_state_t        state;
    grant_t            last_grant;
    grant_t            cur_grant;
    grant_t            pick;
    logic [CNT_W-1:0]  cnt;
    logic [ADDR_W-1:0] lat_addr;
    logic              lat_we;
    logic [DATA_W-1:0] lat_wdata;
    logic [DATA_W-1:0] if_rdata_q;
    logic [DATA_W-1:0] d_rdata_q;

    // Only meaningful in IDLE with at least one request high
    always_comb begin
        pick = INSTR;
        if (d_req && (!if_req || last_grant == INSTR))
            pick = DATA;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            last_grant <= LAST_GRANT_RST;
            cur_grant  <= LAST_GRANT_RST;
            cnt        <= '0;
            lat_addr   <= '0;
            lat_we     <= 1'b0;
            lat_wdata  <= '0;
            if_rdata_q <= '0;
            d_rdata_q  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (if_req || d_req) begin
                        cur_grant <= pick;
                        if (pick == DATA) begin
                            lat_addr  <= d_addr;
                            lat_we    <= d_we;
                            lat_wdata <= d_wdata;
                        end else begin
                            lat_addr  <= if_addr;
                            lat_we    <= 1'b0;
                            lat_wdata <= '0;
                        end
                        state <= ISSUE;
                    end
                end
                ISSUE: begin
                    cnt        <= LAT_LOAD;
                    last_grant <= cur_grant;
                    state      <= WAIT;
                end
                WAIT: begin
                    if (cnt == '0) begin
                        if (!lat_we) begin
                            if (cur_grant == DATA)
                                d_rdata_q <= mem_rdata;
                            else
                                if_rdata_q <= mem_rdata;
                        end
                        state <= RESP;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Everything below decodes registered state only, so no req input reaches an output
    assign mem_en    = (state == ISSUE);
    assign mem_we    = lat_we && (state == ISSUE || state == WAIT);
    assign mem_addr  = lat_addr;
    assign mem_wdata = lat_wdata;
    assign if_ready  = (state == RESP) && (cur_grant == INSTR);
    assign d_ready   = (state == RESP) && (cur_grant == DATA);
    assign if_rdata  = if_rdata_q;
    assign d_rdata   = d_rdata_q;
    assign busy      = (state != IDLE);

endmodule

// File: tb/tb_mips_mem_arbiter.sv
// Bench for mips_mem_arbiter: directed scenarios with literal expectations, then randomized requesters.
module tb_mips_mem_arbiter;

    localparam int LAT = 2;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = '0;
    logic        if_ready;
    logic [31:0] if_rdata;
    logic        d_req = 1'b0;
    logic        d_we = 1'b0;
    logic [31:0] d_addr = '0;
    logic [31:0] d_wdata = '0;
    logic        d_ready;
    logic [31:0] d_rdata;
    logic        mem_en;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        busy;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    always #5 clock = ~clock;
    always @(posedge clock) cyc++;

    mips_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(LAT)) dut (
        .clock(clock), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_ready(if_ready), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ready(d_ready), .d_rdata(d_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .busy(busy)
    );

    function automatic logic [31:0] init_word(input logic [3:0] i);
        case (i)
            4'd0:    return 32'h0000_1111;
            4'd1:    return 32'h2008_0005;
            4'd4:    return 32'h1234_5678;
            default: return {16'hC0DE, 12'h000, i};
        endcase
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Memory model: word valid exactly LAT cycles after the mem_en cycle, garbage otherwise
    bit          mem_v [16];
    logic [31:0] mem_w [16];
    logic [LAT-1:0] en_pipe;
    logic [3:0]  cap_idx = '0;

    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            en_pipe <= '0;
        end else begin
            en_pipe <= (en_pipe << 1) | LAT'(mem_en);
            if (mem_en) begin
                cap_idx <= mem_addr[5:2];
                if (mem_we) begin
                    mem_v[mem_addr[5:2]] <= 1'b1;
                    mem_w[mem_addr[5:2]] <= mem_wdata;
                end
            end
        end
    end

    assign mem_rdata = en_pipe[LAT-1] ? (mem_v[cap_idx] ? mem_w[cap_idx] : init_word(cap_idx))
                                      : 32'hA5A5_5A5A;

    // Reference model: k = cycle index within the current access (0 = idle), per the timeline
    bit          ref_v [16];
    logic [31:0] ref_w [16];
    int          k = 0;
    bit          w_d = 1'b0;
    bit          last_d = 1'b0;
    logic [31:0] a_addr = '0;
    logic [31:0] a_wdata = '0;
    bit          a_we = 1'b0;
    logic [31:0] e_if = '0;
    logic [31:0] e_d = '0;

    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            k = 0; last_d = 1'b0; e_if = '0; e_d = '0;
        end else if (k == 0) begin
            if (if_req || d_req) begin
                w_d     = d_req && (!if_req || !last_d);
                last_d  = w_d;
                a_addr  = w_d ? d_addr : if_addr;
                a_we    = w_d && d_we;
                a_wdata = d_wdata;
                k       = 1;
            end
        end else begin
            if (k == 1 && a_we) begin
                ref_v[a_addr[5:2]] = 1'b1;
                ref_w[a_addr[5:2]] = a_wdata;
            end
            if (k == LAT + 1 && !a_we) begin
                if (w_d) e_d  = ref_v[a_addr[5:2]] ? ref_w[a_addr[5:2]] : init_word(a_addr[5:2]);
                else     e_if = ref_v[a_addr[5:2]] ? ref_w[a_addr[5:2]] : init_word(a_addr[5:2]);
            end
            k = (k == LAT + 2) ? 0 : k + 1;
        end
    end

    always @(negedge clock) begin
        chk("busy", busy, k != 0);
        chk("mem_en", mem_en, k == 1);
        chk("if_ready", if_ready, k == LAT + 2 && !w_d);
        chk("d_ready", d_ready, k == LAT + 2 && w_d);
        chk("if_rdata", if_rdata, e_if);
        chk("d_rdata", d_rdata, e_d);
        if (k >= 1 && k <= LAT + 1) begin
            chk("mem_addr", mem_addr, a_addr);
            chk("mem_we", mem_we, a_we);
            if (a_we) chk("mem_wdata", mem_wdata, a_wdata);
        end
        if (!reset) begin
            chk("rst_mem_addr", mem_addr, 32'h0);
            chk("rst_mem_we", mem_we, 1'b0);
            chk("rst_mem_wdata", mem_wdata, 32'h0);
        end
    end

    int want_i = 0;
    int want_d = 0;
    int ev_port[$];
    int ev_rel[$];

    task automatic tick();
        @(negedge clock);
        #1;
    endtask

    // Advance until each port has seen its wanted number of ready pulses
    task automatic run(input int t0, input int budget);
        ev_port.delete();
        ev_rel.delete();
        for (int n = 0; n < budget && (want_i > 0 || want_d > 0); n++) begin
            tick();
            if (if_ready) begin
                ev_port.push_back(0); ev_rel.push_back(cyc - t0);
                want_i--;
                if (want_i == 0) if_req = 1'b0;
            end
            if (d_ready) begin
                ev_port.push_back(1); ev_rel.push_back(cyc - t0);
                want_d--;
                if (want_d == 0) d_req = 1'b0;
            end
        end
        if (want_i > 0 || want_d > 0) begin
            chk("run_timeout", 32'(want_i + want_d), 32'h0);
            want_i = 0; want_d = 0; if_req = 1'b0; d_req = 1'b0;
        end
    endtask

    function automatic logic [31:0] rand_addr();
        return {26'd0, 4'($urandom_range(0, 15)), 2'b00};
    endfunction

    initial begin
        int t0;
        int done;
        bit i_out;
        bit d_out;

        // Reset held with both requests high
        #1 reset = 1'b0;
        if_req = 1'b1; d_req = 1'b1; if_addr = 32'h4; d_addr = 32'h8;
        repeat (2) begin
            tick();
            chk("rst_busy", busy, 1'b0);
            chk("rst_en", mem_en, 1'b0);
            chk("rst_ifrdy", if_ready, 1'b0);
            chk("rst_drdy", d_ready, 1'b0);
            chk("rst_ifrdata", if_rdata, 32'h0);
            chk("rst_drdata", d_rdata, 32'h0);
        end
        reset = 1'b1; if_req = 1'b0; d_req = 1'b0;
        tick();

        // Tie after reset: data first
        if_req = 1'b1; if_addr = 32'h0;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h10;
        want_i = 1; want_d = 1; t0 = cyc;
        run(t0, 40);
        chk("tie_n", 32'(ev_port.size()), 32'd2);
        if (ev_port.size() == 2) begin
            chk("tie_first_port", 32'(ev_port[0]), 32'd1);
            chk("tie_d_rel", 32'(ev_rel[0]), 32'd4);
            chk("tie_if_rel", 32'(ev_rel[1]), 32'd9);
        end
        chk("tie_d_rdata", d_rdata, 32'h1234_5678);
        chk("tie_if_rdata", if_rdata, 32'h0000_1111);
        tick();

        // Store
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h10; d_wdata = 32'hDEAD_BEEF;
        want_d = 1; t0 = cyc;
        tick();
        chk("st_en", mem_en, 1'b1);
        chk("st_we", mem_we, 1'b1);
        chk("st_wdata", mem_wdata, 32'hDEAD_BEEF);
        run(t0, 40);
        if (ev_rel.size() > 0) chk("st_rel", 32'(ev_rel[0]), 32'd4);
        chk("st_d_rdata", d_rdata, 32'h1234_5678);
        d_we = 1'b0;
        tick();

        // Single fetch
        if_req = 1'b1; if_addr = 32'h4;
        want_i = 1; t0 = cyc;
        tick();
        chk("f_en", mem_en, 1'b1);
        chk("f_addr", mem_addr, 32'h4);
        chk("f_busy", busy, 1'b1);
        run(t0, 40);
        if (ev_rel.size() > 0) chk("f_rel", 32'(ev_rel[0]), 32'd4);
        chk("f_rdata", if_rdata, 32'h2008_0005);
        tick();
        chk("f_busy_end", busy, 1'b0);

        // Fairness: both held for four accesses
        if_req = 1'b1; if_addr = 32'h4;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h10;
        want_i = 2; want_d = 2; t0 = cyc;
        run(t0, 80);
        chk("fair_n", 32'(ev_port.size()), 32'd4);
        for (int j = 0; j < 4 && j < ev_port.size(); j++) begin
            chk("fair_port", 32'(ev_port[j]), 32'((j % 2 == 0) ? 1 : 0));
            chk("fair_rel", 32'(ev_rel[j]), 32'(4 + 5 * j));
        end
        tick();

        // Reset in WAIT abandons the fetch
        if_req = 1'b1; if_addr = 32'h8;
        tick(); tick();
        reset = 1'b0;
        #1;
        chk("rw_busy", busy, 1'b0);
        chk("rw_en", mem_en, 1'b0);
        chk("rw_ifrdata", if_rdata, 32'h0);
        chk("rw_drdata", d_rdata, 32'h0);
        tick();
        chk("rw_ifrdy", if_ready, 1'b0);
        tick();
        chk("rw_ifrdy2", if_ready, 1'b0);
        reset = 1'b1; if_req = 1'b0;
        tick();
        if_req = 1'b1; if_addr = 32'h0;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h10;
        want_i = 1; want_d = 1; t0 = cyc;
        run(t0, 40);
        if (ev_port.size() > 0) begin
            chk("rw_tie_port", 32'(ev_port[0]), 32'd1);
            chk("rw_tie_rel", 32'(ev_rel[0]), 32'd4);
        end
        chk("rw_tie_drdata", d_rdata, 32'hDEAD_BEEF);
        tick();

        // Randomized requesters checked by the per-cycle model
        done = 0; i_out = 1'b0; d_out = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            tick();
            if (i_out) begin
                if (if_ready) begin
                    done++; i_out = 1'b0; if_req = 1'b0;
                end else if (k >= 1 && !w_d) begin
                    if ($urandom_range(0, 19) == 0) if_req = 1'b0;
                    if ($urandom_range(0, 9) == 0) if_addr = rand_addr();
                end
            end
            if (!i_out && $urandom_range(0, 3) == 0) begin
                i_out = 1'b1; if_req = 1'b1; if_addr = rand_addr();
            end
            if (d_out) begin
                if (d_ready) begin
                    done++; d_out = 1'b0; d_req = 1'b0;
                end else if (k >= 1 && w_d) begin
                    if ($urandom_range(0, 19) == 0) d_req = 1'b0;
                    if ($urandom_range(0, 9) == 0) begin
                        d_addr = rand_addr(); d_wdata = $urandom(); d_we = 1'($urandom_range(0, 1));
                    end
                end
            end
            if (!d_out && $urandom_range(0, 3) == 0) begin
                d_out = 1'b1; d_req = 1'b1; d_addr = rand_addr();
                d_we = 1'($urandom_range(0, 1)); d_wdata = $urandom();
            end
        end
        chk("rand_progress", 32'(done > 300), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
